// File: rtl/gui_tool_ctrl.sv
// Drawing-tool control: debounced buttons with auto-repeat step the pending colour/width,
// which are committed to the GUI at frame start; a separate FSM handles the canvas clear.
module gui_tool_ctrl #(
  parameter int unsigned REPEAT_DELAY  = 37_125_000,
  parameter int unsigned REPEAT_PERIOD = 9_281_250,
  parameter int unsigned NUM_COLORS    = 9
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn_color_next,
  input  logic       btn_color_prev,
  input  logic       btn_width_up,
  input  logic       btn_width_dn,
  input  logic       btn_clear,
  input  logic       frame_start,
  input  logic       clear_ack,
  output logic [3:0] cursor_color,
  output logic [2:0] stroke_width,
  output logic       gui_update,
  output logic       clear_req
);

  localparam logic [31:0] Delay    = 32'(REPEAT_DELAY);
  localparam logic [31:0] Period   = 32'(REPEAT_PERIOD);
  localparam logic [31:0] CntMax   = 32'hFFFF_FFFF;
  localparam logic [3:0]  ColorMax = 4'(NUM_COLORS - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRel} clr_state_e;

  // Step buttons: [0] colour next, [1] colour prev, [2] width up, [3] width down.
  logic [3:0]  btn_raw;
  logic [3:0]  step_btn_q;
  logic [31:0] hold_cnt_q [4];
  logic [31:0] next_evt_q [4];
  logic [3:0]  step_ev;
  logic        clr_btn_q, clr_btn_prev_q;
  logic [3:0]  pending_color_q, pending_color_d;
  logic [2:0]  pending_width_q, pending_width_d;
  clr_state_e  clr_state_q;

  assign btn_raw = {btn_width_dn, btn_width_up, btn_color_prev, btn_color_next};

  // next_evt_q holds the hold count of the upcoming repeat event, avoiding a modulo.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      step_ev[i] = step_btn_q[i] && (hold_cnt_q[i] == next_evt_q[i]);
    end
  end

  always_comb begin
    pending_color_d = pending_color_q;
    if (step_ev[0] && !step_ev[1]) begin
      pending_color_d = (pending_color_q == ColorMax) ? 4'd0 : pending_color_q + 4'd1;
    end else if (step_ev[1] && !step_ev[0]) begin
      pending_color_d = (pending_color_q == 4'd0) ? ColorMax : pending_color_q - 4'd1;
    end
  end

  always_comb begin
    pending_width_d = pending_width_q;
    if (step_ev[2] && !step_ev[3]) begin
      if (pending_width_q != 3'd7) pending_width_d = pending_width_q + 3'd1;
    end else if (step_ev[3] && !step_ev[2]) begin
      if (pending_width_q != 3'd1) pending_width_d = pending_width_q - 3'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      step_btn_q      <= '0;
      clr_btn_q       <= 1'b0;
      clr_btn_prev_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hold_cnt_q[i] <= '0;
        next_evt_q[i] <= '0;
      end
      pending_color_q <= 4'd1;
      pending_width_q <= 3'd1;
      cursor_color    <= 4'd1;
      stroke_width    <= 3'd1;
      gui_update      <= 1'b0;
      clr_state_q     <= StIdle;
      clear_req       <= 1'b0;
    end else begin
      step_btn_q     <= btn_raw;
      clr_btn_q      <= btn_clear;
      clr_btn_prev_q <= clr_btn_q;
      for (int i = 0; i < 4; i++) begin
        if (!step_btn_q[i]) begin
          hold_cnt_q[i] <= '0;
          next_evt_q[i] <= '0;
        end else begin
          if (hold_cnt_q[i] != CntMax) hold_cnt_q[i] <= hold_cnt_q[i] + 32'd1;
          if (step_ev[i]) begin
            next_evt_q[i] <= (hold_cnt_q[i] == '0) ? Delay : next_evt_q[i] + Period;
          end
        end
      end

      pending_color_q <= pending_color_d;
      pending_width_q <= pending_width_d;

      // Commit takes the pre-step pending value; a coincident step lands next frame.
      if (frame_start) begin
        cursor_color <= pending_color_q;
        stroke_width <= pending_width_q;
        gui_update   <= (pending_color_q != cursor_color) || (pending_width_q != stroke_width);
      end else begin
        gui_update   <= 1'b0;
      end

      case (clr_state_q)
        StIdle: begin
          if (clr_btn_q && !clr_btn_prev_q) begin
            clr_state_q <= StReq;
            clear_req   <= 1'b1;
          end
        end
        StReq: begin
          if (clear_ack) begin
            clr_state_q <= StWaitRel;
            clear_req   <= 1'b0;
          end
        end
        StWaitRel: begin
          if (!clr_btn_q && !clear_ack) clr_state_q <= StIdle;
        end
        default: begin
          clr_state_q <= StIdle;
          clear_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gui_tool_ctrl.sv
// Bench for gui_tool_ctrl: directed scenarios plus random button traffic, scored against a
// hold-time reference model through an expected-commit queue.
module tb_gui_tool_ctrl;

  localparam int RD = 4;
  localparam int RP = 2;
  localparam int NC = 9;

  localparam logic [4:0] BNext = 5'b00001;
  localparam logic [4:0] BPrev = 5'b00010;
  localparam logic [4:0] BUp   = 5'b00100;
  localparam logic [4:0] BClr  = 5'b10000;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       btn_color_next = 1'b0, btn_color_prev = 1'b0;
  logic       btn_width_up = 1'b0, btn_width_dn = 1'b0, btn_clear = 1'b0;
  logic       frame_start = 1'b0, clear_ack = 1'b0;
  logic [3:0] cursor_color;
  logic [2:0] stroke_width;
  logic       gui_update, clear_req;

  always #5 clk_in = ~clk_in;

  gui_tool_ctrl #(
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .NUM_COLORS   (NC)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .btn_color_next(btn_color_next),
    .btn_color_prev(btn_color_prev),
    .btn_width_up  (btn_width_up),
    .btn_width_dn  (btn_width_dn),
    .btn_clear     (btn_clear),
    .frame_start   (frame_start),
    .clear_ack     (clear_ack),
    .cursor_color  (cursor_color),
    .stroke_width  (stroke_width),
    .gui_update    (gui_update),
    .clear_req     (clear_req)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: steps follow from how long each button has been held.
  typedef struct {int color; int width; bit upd;} exp_t;
  exp_t exp_q[$];

  int       m_t [4];
  bit [3:0] m_bq = '0;
  bit [3:0] m_new, m_ev;
  bit       m_clr_q = 0, m_clr_prev = 0, m_req = 0;
  int       m_pc = 1, m_pw = 1, m_cc = 1, m_cw = 1;
  int       m_st = 0;  // 0 idle, 1 requesting, 2 waiting for release
  exp_t     m_e;

  function automatic bit is_event(int t);
    return (t == 0) || (t == RD) || (t > RD && ((t - RD) % RP) == 0);
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) m_t[i] = 0;
    forever begin
      @(posedge clk_in);
      if (rst_in) begin
        m_bq = '0; m_clr_q = 0; m_clr_prev = 0;
        for (int i = 0; i < 4; i++) m_t[i] = 0;
        m_pc = 1; m_pw = 1; m_cc = 1; m_cw = 1; m_st = 0; m_req = 0;
        m_e = '{1, 1, 1'b0};
        exp_q.push_back(m_e);
      end else begin
        for (int i = 0; i < 4; i++) m_ev[i] = m_bq[i] && is_event(m_t[i]);
        if (frame_start) begin
          m_e.upd = (m_pc != m_cc) || (m_pw != m_cw);
          m_cc = m_pc; m_cw = m_pw;
          m_e.color = m_cc; m_e.width = m_cw;
          exp_q.push_back(m_e);
        end
        if (m_ev[0] && !m_ev[1]) m_pc = (m_pc + 1) % NC;
        else if (m_ev[1] && !m_ev[0]) m_pc = (m_pc + NC - 1) % NC;
        if (m_ev[2] && !m_ev[3]) m_pw = (m_pw < 7) ? m_pw + 1 : 7;
        else if (m_ev[3] && !m_ev[2]) m_pw = (m_pw > 1) ? m_pw - 1 : 1;
        case (m_st)
          0: if (m_clr_q && !m_clr_prev) m_st = 1;
          1: if (clear_ack) m_st = 2;
          default: if (!m_clr_q && !clear_ack) m_st = 0;
        endcase
        m_req = (m_st == 1);
        m_new = {btn_width_dn, btn_width_up, btn_color_prev, btn_color_next};
        for (int i = 0; i < 4; i++) m_t[i] = (m_new[i] && m_bq[i]) ? m_t[i] + 1 : 0;
        m_bq = m_new;
        m_clr_prev = m_clr_q;
        m_clr_q = btn_clear;
      end
    end
  end

  // Monitor: pops one expected commit per commit edge, otherwise outputs must hold.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk_in);
      check("clear_req", 32'(clear_req), 32'(m_req));
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("commit_color", 32'(cursor_color), 32'(mon_e.color));
        check("commit_width", 32'(stroke_width), 32'(mon_e.width));
        check("commit_update", 32'(gui_update), 32'(mon_e.upd));
      end else begin
        check("idle_update", 32'(gui_update), 32'd0);
        check("hold_color", 32'(cursor_color), 32'(m_cc));
        check("hold_width", 32'(stroke_width), 32'(m_cw));
      end
    end
  end

  task automatic tick(input logic [4:0] b, input logic fs, input logic ack);
    @(negedge clk_in);
    {btn_clear, btn_width_dn, btn_width_up, btn_color_prev, btn_color_next} = b;
    frame_start = fs;
    clear_ack   = ack;
  endtask

  task automatic settle();
    @(posedge clk_in);
    #1;
  endtask

  logic [4:0] rb;
  logic       rack;

  initial begin
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    tick(5'd0, 1'b0, 1'b0);
    tick(5'd0, 1'b1, 1'b0);
    settle();
    check("reset_color", 32'(cursor_color), 32'd1);
    check("reset_width", 32'(stroke_width), 32'd1);
    check("reset_update", 32'(gui_update), 32'd0);

    repeat (8) begin
      tick(BNext, 1'b0, 1'b0);
      tick(5'd0, 1'b0, 1'b0);
    end
    repeat (2) tick(5'd0, 1'b0, 1'b0);
    tick(5'd0, 1'b1, 1'b0);
    settle();
    check("wrap_color", 32'(cursor_color), 32'd0);
    check("wrap_update", 32'(gui_update), 32'd1);

    repeat (10) tick(BUp, 1'b0, 1'b0);
    repeat (3) tick(5'd0, 1'b0, 1'b0);
    tick(5'd0, 1'b1, 1'b0);
    settle();
    check("repeat_width", 32'(stroke_width), 32'd5);
    repeat (20) tick(BUp, 1'b0, 1'b0);
    repeat (3) tick(5'd0, 1'b0, 1'b0);
    tick(5'd0, 1'b1, 1'b0);
    settle();
    check("sat_width", 32'(stroke_width), 32'd7);

    tick(BNext | BPrev, 1'b0, 1'b0);
    repeat (3) tick(5'd0, 1'b0, 1'b0);
    tick(5'd0, 1'b1, 1'b0);
    settle();
    check("cancel_color", 32'(cursor_color), 32'd0);
    check("cancel_update", 32'(gui_update), 32'd0);

    tick(BNext, 1'b0, 1'b0);
    tick(5'd0, 1'b1, 1'b0);
    settle();
    check("coincide_color", 32'(cursor_color), 32'd0);
    tick(5'd0, 1'b0, 1'b0);
    tick(5'd0, 1'b1, 1'b0);
    settle();
    check("late_color", 32'(cursor_color), 32'd1);
    check("late_update", 32'(gui_update), 32'd1);

    tick(BClr, 1'b0, 1'b0);
    tick(BClr, 1'b0, 1'b0);
    settle();
    check("clr_rise", 32'(clear_req), 32'd1);
    repeat (3) tick(BClr, 1'b0, 1'b0);
    settle();
    check("clr_hold", 32'(clear_req), 32'd1);
    tick(BClr, 1'b0, 1'b1);
    settle();
    check("clr_ack", 32'(clear_req), 32'd0);
    repeat (2) tick(5'd0, 1'b0, 1'b1);
    repeat (2) tick(BClr, 1'b0, 1'b1);
    tick(5'd0, 1'b0, 1'b1);
    repeat (4) tick(5'd0, 1'b0, 1'b0);
    settle();
    check("clr_ignored", 32'(clear_req), 32'd0);

    tick(BClr, 1'b0, 1'b0);
    tick(BClr | BUp, 1'b0, 1'b0);
    settle();
    check("rst_pre_req", 32'(clear_req), 32'd1);
    @(negedge clk_in);
    rst_in = 1'b1;
    {btn_clear, btn_width_dn, btn_width_up, btn_color_prev, btn_color_next} = BUp;
    settle();
    check("rst_req_drop", 32'(clear_req), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) tick(BUp, 1'b0, 1'b0);
    repeat (3) tick(5'd0, 1'b0, 1'b0);
    tick(5'd0, 1'b1, 1'b0);
    settle();
    check("rst_one_step", 32'(stroke_width), 32'd2);

    rb = '0;
    rack = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clk_in);
        rst_in = 1'b1;
        frame_start = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk_in);
        rst_in = 1'b0;
      end
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 7) == 0) rb[i] = ~rb[i];
      if (clear_req) rack = ($urandom_range(0, 2) == 0);
      else if (rack) rack = ($urandom_range(0, 1) == 0);
      tick(rb, ($urandom_range(0, 5) == 0), rack);
    end
    tick(5'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
